// File: rtl/logic_pipe_pkg.sv
// Shared definitions for the logic pipe unit: ALU opcodes and FSM state encoding.
package logic_pipe_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOTX = 3'b110;
  localparam logic [2:0] OP_PASY = 3'b111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

endpackage

// File: rtl/logic_pipe_unit_core.sv
// Combinational 8-op bitwise function of X and Y.
module logic_op_core
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       fun,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (fun)
      OP_AND:  result = x & y;
      OP_OR:   result = x | y;
      OP_NAND: result = ~(x & y);
      OP_NOR:  result = ~(x | y);
      OP_XOR:  result = x ^ y;
      OP_XNOR: result = ~(x ^ y);
      OP_NOTX: result = ~x;
      OP_PASY: result = y;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/logic_pipe_unit.sv
// One-deep registered logic pipe with optional burst accumulation and a
// saturating beat counter.
module logic_pipe_unit
  import logic_pipe_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int MAX_BEATS = 15,
  localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_FUN,
  input  logic             ACC_EN,
  input  logic             IN_LAST,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Logic_OUT,
  output logic             Zero_Flag,
  output logic             Parity_Flag,
  output logic             Abort_Flag,
  output logic [CNT_W-1:0] Burst_Len
);

  localparam logic [CNT_W:0] MAX_CNT = (CNT_W + 1)'(MAX_BEATS);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, x, f;
  logic [CNT_W-1:0] count, cnt_sat, len_nxt;
  logic [CNT_W:0]   cnt_inc;
  logic             fire, emit, abort, acc_load;

  assign IN_READY = !RST && (!OUT_VALID || OUT_READY);
  assign fire     = IN_VALID && IN_READY;
  // An aborting beat (ACC_EN=0 inside a burst) starts fresh from A.
  assign x        = (state == S_ACC && ACC_EN) ? acc : A;
  // One extra bit so count+1 cannot wrap before the clamp.
  assign cnt_inc  = {1'b0, count} + (CNT_W + 1)'(1);
  assign cnt_sat  = (cnt_inc > MAX_CNT) ? MAX_CNT[CNT_W-1:0] : cnt_inc[CNT_W-1:0];

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .x      (x),
    .y      (B),
    .fun    (ALU_FUN),
    .result (f)
  );

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    abort     = 1'b0;
    acc_load  = 1'b0;
    len_nxt   = CNT_W'(1);
    case (state)
      S_IDLE: begin
        if (ACC_EN && !IN_LAST) begin
          acc_load  = 1'b1;
          state_nxt = S_ACC;
        end else begin
          emit = 1'b1;
        end
      end
      S_ACC: begin
        if (!ACC_EN) begin
          emit      = 1'b1;
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          len_nxt = cnt_sat;
          if (IN_LAST) begin
            emit      = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            acc_load = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      acc         <= '0;
      count       <= '0;
      OUT_VALID   <= 1'b0;
      Logic_OUT   <= '0;
      Zero_Flag   <= 1'b0;
      Parity_Flag <= 1'b0;
      Abort_Flag  <= 1'b0;
      Burst_Len   <= '0;
    end else begin
      if (fire) begin
        state <= state_nxt;
        if (acc_load) begin
          acc   <= f;
          count <= len_nxt;
        end
      end
      if (fire && emit) begin
        OUT_VALID   <= 1'b1;
        Logic_OUT   <= f;
        Zero_Flag   <= (f == '0);
        Parity_Flag <= ^f;
        Abort_Flag  <= abort;
        Burst_Len   <= len_nxt;
      end else if (OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_logic_pipe_unit.sv
// Bench for logic_pipe_unit: vector table of single ops plus burst, abort,
// backpressure, reset and saturation sequences, checked through a scoreboard.
module tb_logic_pipe_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID, ACC_EN, IN_LAST, OUT_READY;
  logic [15:0] A, B;
  logic [2:0]  ALU_FUN;

  logic        IN_READY, OUT_VALID, Zero_Flag, Parity_Flag, Abort_Flag;
  logic [15:0] Logic_OUT;
  logic [3:0]  Burst_Len;

  logic        s_in_ready, s_out_valid, s_zero, s_parity, s_abort;
  logic [15:0] s_out;
  logic [2:0]  s_len;

  always #5 CLK = ~CLK;

  logic_pipe_unit #(.WIDTH(16), .MAX_BEATS(15)) u_dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .ALU_FUN(ALU_FUN), .ACC_EN(ACC_EN), .IN_LAST(IN_LAST),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .Logic_OUT(Logic_OUT),
    .Zero_Flag(Zero_Flag), .Parity_Flag(Parity_Flag), .Abort_Flag(Abort_Flag),
    .Burst_Len(Burst_Len)
  );

  // Same stimulus, small saturation limit.
  logic_pipe_unit #(.WIDTH(16), .MAX_BEATS(4)) u_sat (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(s_in_ready),
    .A(A), .B(B), .ALU_FUN(ALU_FUN), .ACC_EN(ACC_EN), .IN_LAST(IN_LAST),
    .OUT_VALID(s_out_valid), .OUT_READY(OUT_READY), .Logic_OUT(s_out),
    .Zero_Flag(s_zero), .Parity_Flag(s_parity), .Abort_Flag(s_abort),
    .Burst_Len(s_len)
  );

  typedef struct {
    logic [15:0] data;
    logic        abort;
    int          len;
  } exp_t;

  typedef struct {
    logic [15:0] a, b;
    logic [2:0]  fun;
    logic        acc_en, last;
    logic [15:0] exp;
  } vec_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Handshake at the next rising edge is visible here, mid-cycle.
  always @(negedge CLK) begin
    if (!RST && OUT_VALID && OUT_READY) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got %0h expected none", Logic_OUT);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data",   Logic_OUT,   e.data);
        chk("zero",   Zero_Flag,   e.data == 16'h0);
        chk("parity", Parity_Flag, ^e.data);
        chk("abort",  Abort_Flag,  e.abort);
        chk("len",    Burst_Len,   e.len);
        chk("sat_valid", s_out_valid, 1);
        chk("sat_data",  s_out,       e.data);
        chk("sat_len",   s_len,       (e.len > 4) ? 4 : e.len);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] fun,
                      input logic acc_en, input logic last, input logic emit,
                      input logic [15:0] ed, input logic ea, input int el);
    int n;
    exp_t e;
    A = a; B = b; ALU_FUN = fun; ACC_EN = acc_en; IN_LAST = last; IN_VALID = 1'b1;
    if (emit) begin
      e.data = ed; e.abort = ea; e.len = el;
      sb.push_back(e);
    end
    n = 0;
    @(negedge CLK);
    while (!IN_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!IN_READY) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got IN_READY=0 expected 1");
    end
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge CLK);
      n++;
    end
    #1;
    chk("drain_remaining", sb.size(), 0);
  endtask

  vec_t vt[10];

  initial begin
    vt[0] = '{16'hF0F0, 16'hFF00, 3'b000, 1'b0, 1'b0, 16'hF000};
    vt[1] = '{16'hF0F0, 16'hFF00, 3'b001, 1'b0, 1'b0, 16'hFFF0};
    vt[2] = '{16'hF0F0, 16'hFF00, 3'b010, 1'b0, 1'b0, 16'h0FFF};
    vt[3] = '{16'hF0F0, 16'hFF00, 3'b011, 1'b0, 1'b0, 16'h000F};
    vt[4] = '{16'hF0F0, 16'hFF00, 3'b100, 1'b0, 1'b0, 16'h0FF0};
    vt[5] = '{16'hF0F0, 16'hFF00, 3'b101, 1'b0, 1'b1, 16'hF00F};
    vt[6] = '{16'hF0F0, 16'hFF00, 3'b110, 1'b0, 1'b0, 16'h0F0F};
    vt[7] = '{16'hF0F0, 16'hFF00, 3'b111, 1'b0, 1'b1, 16'hFF00};
    vt[8] = '{16'h00FF, 16'hFF00, 3'b000, 1'b0, 1'b0, 16'h0000};
    vt[9] = '{16'h8001, 16'h0001, 3'b001, 1'b1, 1'b1, 16'h8001};

    RST = 1'b1; IN_VALID = 1'b0; A = '0; B = '0; ALU_FUN = '0;
    ACC_EN = 1'b0; IN_LAST = 1'b0; OUT_READY = 1'b1;

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_logic_out", Logic_OUT, 0);
    chk("rst_in_ready",  IN_READY, 0);
    chk("rst_burst_len", Burst_Len, 0);
    chk("rst_flags", {Zero_Flag, Parity_Flag, Abort_Flag}, 0);
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_in_ready", IN_READY, 1);
    @(posedge CLK);
    #1;

    // Single-op vectors, back to back
    for (int i = 0; i < 10; i++)
      send(vt[i].a, vt[i].b, vt[i].fun, vt[i].acc_en, vt[i].last, 1'b1, vt[i].exp, 1'b0, 1);
    drain();

    // Backpressure: first result held while second beat waits
    OUT_READY = 1'b0;
    send(16'hF0F0, 16'hFF00, 3'b100, 1'b0, 1'b0, 1'b1, 16'h0FF0, 1'b0, 1);
    A = 16'h1234; B = 16'h00FF; ALU_FUN = 3'b000; ACC_EN = 1'b0; IN_LAST = 1'b0;
    IN_VALID = 1'b1;
    sb.push_back('{16'h0034, 1'b0, 1});
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("bp_in_ready",  IN_READY, 0);
      chk("bp_out_valid", OUT_VALID, 1);
      chk("bp_hold_data", Logic_OUT, 16'h0FF0);
    end
    @(posedge CLK);
    #1 OUT_READY = 1'b1;
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
    drain();

    // Accumulate OR burst
    send(16'h0001, 16'h0002, 3'b001, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 0);
    send(16'hAAAA, 16'h0004, 3'b001, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 0);
    send(16'hAAAA, 16'h0008, 3'b001, 1'b1, 1'b1, 1'b1, 16'h000F, 1'b0, 3);
    drain();

    // Per-beat op change inside a burst
    send(16'hFFFF, 16'h0F0F, 3'b000, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 0);
    send(16'h0000, 16'h00FF, 3'b100, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 0);
    send(16'h0000, 16'h1234, 3'b110, 1'b1, 1'b1, 1'b1, 16'hF00F, 1'b0, 3);
    drain();

    // Abort, then confirm the FSM is idle (single-beat burst uses A)
    send(16'h0001, 16'h0002, 3'b001, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 0);
    send(16'hFFFF, 16'h00FF, 3'b000, 1'b0, 1'b0, 1'b1, 16'h00FF, 1'b1, 1);
    send(16'h1234, 16'hFFFF, 3'b000, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 1);
    drain();

    // Reset mid-burst drops the partial accumulation
    send(16'h0001, 16'h0002, 3'b001, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 0);
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    send(16'h0100, 16'h0001, 3'b001, 1'b1, 1'b1, 1'b1, 16'h0101, 1'b0, 1);
    drain();

    // 6-beat XOR burst: len 6 on the default unit, clamped to 4 on u_sat
    send(16'hA5A5, 16'h0001, 3'b100, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 0);
    send(16'h0000, 16'h0010, 3'b100, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 0);
    send(16'h0000, 16'h0100, 3'b100, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 0);
    send(16'h0000, 16'h1000, 3'b100, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 0);
    send(16'h0000, 16'hFFFF, 3'b100, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 0);
    send(16'h0000, 16'h0F0F, 3'b100, 1'b1, 1'b1, 1'b1, 16'h4444, 1'b0, 6);
    drain();

    repeat (3) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/logic_pipe_unit.md
LOGIC_PIPE_UNIT -- requirements
Module: logic_pipe_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, which sets the operand and result width in bits.
REQ-002 The block SHALL have parameter MAX_BEATS, default 15, which sets the burst-length saturation value; CNT_W = $clog2(MAX_BEATS+1).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports:
- CLK  in  1  clock, all logic on the rising edge.
- RST  in  1  synchronous active-high reset.
REQ-004 The block SHALL have these ports:
- IN_VALID  in  1  input beat offered.
- IN_READY  out  1  input beat accepted when IN_VALID&IN_READY.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- ALU_FUN  in  3  operation select.
- ACC_EN  in  1  beat belongs to an accumulate burst.
- IN_LAST  in  1  final beat of a burst; ignored when ACC_EN=0.
- OUT_VALID  out  1  result held.
- OUT_READY  in  1  result consumed when OUT_VALID&OUT_READY.
- Logic_OUT  out  WIDTH  result.
- Zero_Flag  out  1  Logic_OUT==0.
- Parity_Flag  out  1  XOR-reduction of Logic_OUT.
- Abort_Flag  out  1  result follows an abandoned burst.
- Burst_Len  out  CNT_W  number of beats folded into the result.

Function
REQ-005 ALU_FUN SHALL decode as follows: 000 X&Y, 001 X|Y, 010 ~(X&Y), 011 ~(X|Y), 100 X^Y, 101 ~(X^Y), 110 ~X, 111 Y.
REQ-006 X SHALL be A, except within an open burst, where X is the accumulator; Y SHALL always be B.
REQ-007 IN_READY SHALL equal !RST && (!OUT_VALID || OUT_READY).
REQ-008 The FSM SHALL have two states: S_IDLE (no burst open) and S_ACC (burst open).
REQ-009 In S_IDLE, an accepted beat with ACC_EN=0 SHALL load the output register with f(A,B), Burst_Len=1 and Abort_Flag=0; the state SHALL remain S_IDLE.
REQ-010 In S_IDLE, an accepted beat with ACC_EN=1 and IN_LAST=0 SHALL set acc=f(A,B) and count=1, SHALL produce no output, and SHALL move to S_ACC.
REQ-011 In S_IDLE, an accepted beat with ACC_EN=1 and IN_LAST=1 SHALL emit f(A,B) with Burst_Len=1 and stay in S_IDLE.
REQ-012 In S_ACC, an accepted beat with ACC_EN=1 and IN_LAST=0 SHALL set acc=f(acc,B) and count=sat(count+1), and SHALL produce no output.
REQ-013 In S_ACC, an accepted beat with ACC_EN=1 and IN_LAST=1 SHALL emit f(acc,B) with Burst_Len=sat(count+1), then go to S_IDLE.
REQ-014 In S_ACC, an accepted beat with ACC_EN=0 SHALL discard the accumulator and emit f(A,B) with Burst_Len=1 and Abort_Flag=1, then go to S_IDLE.
REQ-015 ALU_FUN SHALL be sampled per beat, so each beat of a burst may use a different op.
REQ-016 sat() SHALL clamp at MAX_BEATS with no wrap-around.
REQ-017 Latency SHALL be 1 cycle: an emitting beat accepted at edge n gives OUT_VALID=1 after edge n.
REQ-018 Logic_OUT and all flags SHALL be registered and SHALL stay stable while OUT_VALID&&!OUT_READY.
REQ-019 OUT_VALID SHALL clear after a consume edge unless a new emitting beat is accepted on the same edge, in which case it stays 1 with the new data.
REQ-020 Non-emitting beats SHALL be accepted under the same IN_READY rule.
REQ-021 IN_VALID=0 SHALL change no state.

Reset
REQ-022 While RST=1 at an edge, the block SHALL force OUT_VALID=0, Logic_OUT=0, all flags 0, Burst_Len=0, acc=0, count=0 and state S_IDLE.
REQ-023 RST asserted mid-burst SHALL drop the partial accumulation without emitting a result.
REQ-024 The first beat after RST release SHALL be accepted on the first edge with IN_READY=1.

Structure
REQ-025 A shared package logic_pipe_pkg SHALL hold the ALU_FUN opcode localparams and the FSM state encoding.
REQ-026 The 8-op function SHALL be a combinational sub-module, logic_op_core #(WIDTH), instantiated once.

Verification
REQ-027 Reset check: hold RST=1 for 2 cycles -> OUT_VALID=0, Logic_OUT=0, IN_READY=0; after release, IN_READY=1.
REQ-028 Single op, WIDTH=16: A=F0F0, B=FF00, ALU_FUN=100 -> next cycle Logic_OUT=0FF0, Zero_Flag=0, Parity_Flag=0, Burst_Len=1.
REQ-029 Backpressure: OUT_READY=0 for 3 cycles while a second beat is offered -> IN_READY=0 and Logic_OUT unchanged; then OUT_READY=1 -> both results appear in order with no loss.
REQ-030 Accumulate: ALU_FUN=001, beats (A=0001,B=0002), (B=0004), (B=0008, IN_LAST) -> OUT_VALID only after the third beat, Logic_OUT=000F, Burst_Len=3.
REQ-031 Abort: open a burst, then send ACC_EN=0, ALU_FUN=000, A=FFFF, B=00FF -> Logic_OUT=00FF, Abort_Flag=1, Burst_Len=1, state S_IDLE.
REQ-032 Saturation: with MAX_BEATS=4, send a 6-beat XOR burst -> Burst_Len=4 and the result equals the XOR of all 6 B values with the first A.
